// File: rtl/multicycle_cpu_core.sv
// Multi-cycle CPU core: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK engine with an internal
// register file and ALU, talking to external instruction/data memories over req/ready.
module multicycle_cpu_core #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int PC_W     = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [15:0]       dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              retire,
  output logic              halted
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;
  localparam logic [2:0] OP_ST  = 3'd5;
  localparam logic [2:0] OP_BEQ = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALTED
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [PC_W-1:0]     r_pc;
  logic [31:0]         r_instr;
  logic [DATA_W-1:0]   r_opA, r_opB, r_opD, r_result;
  logic [15:0]         r_dmemAddr;
  logic [DATA_W-1:0]   r_dmemWdata;
  logic [DATA_W-1:0]   r_regs [1:NUM_REGS-1];

  logic [2:0]          w_op;
  logic [4:0]          w_rd, w_rs0, w_rs1;
  logic [15:0]         w_imm, w_memAddr;
  logic [DATA_W-1:0]   w_rs0Val, w_rs1Val, w_rdVal, w_aluResult;
  logic                w_writeEn;

  assign w_op      = r_instr[31:29];
  assign w_rd      = r_instr[28:24];
  assign w_rs0     = r_instr[23:19];
  assign w_rs1     = r_instr[18:14];
  assign w_imm     = r_instr[15:0];
  assign w_memAddr = r_opA[15:0] + w_imm;
  assign w_writeEn = (r_state == S_WRITEBACK) && ((w_op[2] == 1'b0) || (w_op == OP_LD));

  // r0 and indices beyond the implemented range both read as zero.
  always_comb begin
    w_rs0Val = '0;
    w_rs1Val = '0;
    w_rdVal  = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (w_rs0 == 5'(i)) w_rs0Val = r_regs[i];
      if (w_rs1 == 5'(i)) w_rs1Val = r_regs[i];
      if (w_rd  == 5'(i)) w_rdVal  = r_regs[i];
    end
  end

  always_comb begin
    w_aluResult = '0;
    case (w_op)
      OP_ADD:  w_aluResult = r_opA + r_opB;
      OP_SUB:  w_aluResult = r_opA - r_opB;
      OP_AND:  w_aluResult = r_opA & r_opB;
      OP_OR:   w_aluResult = r_opA | r_opB;
      default: w_aluResult = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_FETCH:     if (imem_ready) w_nextState = S_DECODE;
      S_DECODE:    w_nextState = S_EXECUTE;
      S_EXECUTE:   w_nextState = ((w_op == OP_LD) || (w_op == OP_ST)) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY:    if (dmem_ready) w_nextState = S_WRITEBACK;
      S_WRITEBACK: w_nextState = (w_op == OP_HLT) ? S_HALTED : S_FETCH;
      S_HALTED:    w_nextState = S_HALTED;
      default:     w_nextState = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= PC_W'(RESET_PC);
      r_instr     <= '0;
      r_opA       <= '0;
      r_opB       <= '0;
      r_opD       <= '0;
      r_result    <= '0;
      r_dmemAddr  <= '0;
      r_dmemWdata <= '0;
      for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_pc    <= r_pc + 1'b1;
          end
        end
        S_DECODE: begin
          r_opA <= w_rs0Val;
          r_opB <= w_rs1Val;
          r_opD <= w_rdVal;
        end
        S_EXECUTE: begin
          r_result <= w_aluResult;
          if ((w_op == OP_LD) || (w_op == OP_ST)) begin
            r_dmemAddr  <= w_memAddr;
            r_dmemWdata <= r_opD;
          end
          // A taken branch replaces the pc already incremented during fetch.
          if ((w_op == OP_BEQ) && (r_opD == r_opA)) r_pc <= w_imm[PC_W-1:0];
        end
        S_MEMORY: begin
          if (dmem_ready && (w_op == OP_LD)) r_result <= dmem_rdata;
        end
        S_WRITEBACK: begin
          for (int i = 1; i < NUM_REGS; i++) begin
            if (w_writeEn && (w_rd == 5'(i))) r_regs[i] <= r_result;
          end
        end
        default: ;
      endcase
    end
  end

  // Requests are masked while rst is high so a handshake is abandoned immediately.
  assign imem_req   = (r_state == S_FETCH) && !rst;
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == S_MEMORY) && !rst;
  assign dmem_we    = dmem_req && (w_op == OP_ST);
  assign dmem_addr  = r_dmemAddr;
  assign dmem_wdata = r_dmemWdata;
  assign pc         = r_pc;
  assign retire     = (r_state == S_WRITEBACK);
  assign halted     = (r_state == S_HALTED);

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed bench for multicycle_cpu_core: a small program exercising ALU ops, loads,
// stores, branches, halt and reset during a stalled fetch against negedge memory models.
module tb_multicycle_cpu_core;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [15:0] pc;
  logic        retire;
  logic        halted;

  int          checks;
  int          failures;
  int          imemWaits;
  int          dmemWaits;
  int          iCnt;
  int          dCnt;
  logic [31:0] ldData;
  logic [15:0] dAddr;
  logic        dWe;
  logic [31:0] dWdata;
  logic        bothReq;
  logic        reqSeen;
  logic [31:0] prog [0:255];

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] LD = 3'd4, ST = 3'd5, BEQ = 3'd6, HLT = 3'd7;

  multicycle_cpu_core dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .retire     (retire),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rType(input logic [2:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs0, input logic [4:0] rs1);
    return {op, rd, rs0, rs1, 14'b0};
  endfunction

  function automatic logic [31:0] iType(input logic [2:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs0, input logic [15:0] imm);
    return {op, rd, rs0, 3'b000, imm};
  endfunction

  // Memory models respond on the falling edge so the core samples ready at the next rise.
  always @(negedge clk) begin
    if (imem_req && dmem_req) bothReq = 1'b1;
    if (imem_req) begin
      if (iCnt >= imemWaits) begin
        imem_ready = 1'b1;
        imem_rdata = prog[imem_addr[7:0]];
      end else begin
        imem_ready = 1'b0;
        iCnt++;
      end
    end else begin
      imem_ready = 1'b0;
      iCnt = 0;
    end
    if (dmem_req) begin
      if (dCnt >= dmemWaits) begin
        dmem_ready = 1'b1;
        dmem_rdata = ldData;
        dAddr      = dmem_addr;
        dWe        = dmem_we;
        dWdata     = dmem_wdata;
      end else begin
        dmem_ready = 1'b0;
        dCnt++;
      end
    end else begin
      dmem_ready = 1'b0;
      dCnt = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from its first fetch cycle up to its retire cycle.
  task automatic applyStimulus(input string tag, input int expCycles, input logic [15:0] expFetch);
    int   cyc;
    logic moved;
    cyc    = 1;
    moved  = 1'b0;
    dAddr  = 16'hxxxx;
    dWe    = 1'bx;
    dWdata = 32'hxxxxxxxx;
    checkOutput({tag, "_fetchAddr"}, {16'h0, imem_addr}, {16'h0, expFetch});
    while (!retire && cyc < 40) begin
      if (imem_req && (imem_addr !== expFetch)) moved = 1'b1;
      stepCycle();
      cyc++;
    end
    checkOutput({tag, "_cycles"}, cyc, expCycles);
    checkOutput({tag, "_addrStable"}, {31'h0, moved}, 32'h0);
  endtask

  task automatic runLoad(input string tag, input int expCycles, input logic [15:0] expFetch,
                         input logic [15:0] expAddr);
    applyStimulus(tag, expCycles, expFetch);
    checkOutput({tag, "_daddr"}, {16'h0, dAddr}, {16'h0, expAddr});
    checkOutput({tag, "_we"}, {31'h0, dWe}, 32'h0);
    stepCycle();
  endtask

  task automatic runStore(input string tag, input logic [15:0] expFetch,
                          input logic [15:0] expAddr, input logic [31:0] expData);
    applyStimulus(tag, 5, expFetch);
    checkOutput({tag, "_daddr"}, {16'h0, dAddr}, {16'h0, expAddr});
    checkOutput({tag, "_we"}, {31'h0, dWe}, 32'h1);
    checkOutput({tag, "_wdata"}, dWdata, expData);
    stepCycle();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    imemWaits  = 0;
    dmemWaits  = 0;
    iCnt       = 0;
    dCnt       = 0;
    ldData     = 32'h0;
    bothReq    = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    for (int i = 0; i < 256; i++) prog[i] = {HLT, 29'h0};
    prog[0]  = rType(ADD, 5'd1, 5'd0, 5'd0);
    prog[1]  = iType(LD, 5'd2, 5'd0, 16'h0010);
    prog[2]  = iType(LD, 5'd5, 5'd2, 16'h0005);
    prog[3]  = iType(LD, 5'd3, 5'd0, 16'h0020);
    prog[4]  = iType(LD, 5'd4, 5'd0, 16'h0021);
    prog[5]  = iType(ST, 5'd3, 5'd4, 16'hFFFF);
    prog[6]  = iType(ST, 5'd5, 5'd0, 16'h0100);
    prog[7]  = iType(ST, 5'd1, 5'd0, 16'h0101);
    prog[8]  = rType(ADD, 5'd7, 5'd5, 5'd3);
    prog[9]  = iType(ST, 5'd7, 5'd0, 16'h0102);
    prog[10] = rType(SUB, 5'd8, 5'd0, 5'd4);
    prog[11] = iType(ST, 5'd8, 5'd0, 16'h0103);
    prog[12] = rType(AND_, 5'd9, 5'd5, 5'd3);
    prog[13] = iType(ST, 5'd9, 5'd0, 16'h0104);
    prog[14] = rType(OR_, 5'd10, 5'd5, 5'd3);
    prog[15] = iType(ST, 5'd10, 5'd0, 16'h0105);
    prog[16] = iType(BEQ, 5'd1, 5'd0, 16'h0040);
    prog[64] = iType(BEQ, 5'd4, 5'd0, 16'h0010);
    prog[65] = iType(LD, 5'd0, 5'd0, 16'h0030);
    prog[66] = iType(ST, 5'd0, 5'd0, 16'h0106);
    prog[67] = {HLT, 29'h0};

    rst = 1'b1;
    repeat (3) stepCycle();
    checkOutput("rst_imemReq", {31'h0, imem_req}, 32'h0);
    checkOutput("rst_imemAddr", {16'h0, imem_addr}, 32'h0);
    checkOutput("rst_pc", {16'h0, pc}, 32'h0);
    checkOutput("rst_dmemReq", {31'h0, dmem_req}, 32'h0);
    checkOutput("rst_dmemWe", {31'h0, dmem_we}, 32'h0);
    checkOutput("rst_dmemAddr", {16'h0, dmem_addr}, 32'h0);
    checkOutput("rst_dmemWdata", dmem_wdata, 32'h0);
    checkOutput("rst_retire", {31'h0, retire}, 32'h0);
    checkOutput("rst_halted", {31'h0, halted}, 32'h0);
    rst = 1'b0;

    applyStimulus("add_r1", 4, 16'h0000);
    checkOutput("add_r1_pc", {16'h0, pc}, 32'h1);
    stepCycle();
    checkOutput("retire_pulse", {31'h0, retire}, 32'h0);

    ldData = 32'h0000_0010;
    runLoad("ld_r2", 5, 16'h0001, 16'h0010);
    ldData = 32'hDEAD_BEEF;
    dmemWaits = 2;
    runLoad("ld_r5", 7, 16'h0002, 16'h0015);
    dmemWaits = 0;
    ldData = 32'h0000_1234;
    imemWaits = 3;
    runLoad("ld_r3_istall", 8, 16'h0003, 16'h0020);
    imemWaits = 0;
    ldData = 32'h0000_0002;
    runLoad("ld_r4", 5, 16'h0004, 16'h0021);

    runStore("st_wrap", 16'h0005, 16'h0001, 32'h0000_1234);
    runStore("st_r5", 16'h0006, 16'h0100, 32'hDEAD_BEEF);
    runStore("st_r1", 16'h0007, 16'h0101, 32'h0000_0000);
    applyStimulus("add_r7", 4, 16'h0008);
    stepCycle();
    runStore("st_add", 16'h0009, 16'h0102, 32'hDEAD_D123);
    applyStimulus("sub_r8", 4, 16'h000A);
    stepCycle();
    runStore("st_sub", 16'h000B, 16'h0103, 32'hFFFF_FFFE);
    applyStimulus("and_r9", 4, 16'h000C);
    stepCycle();
    runStore("st_and", 16'h000D, 16'h0104, 32'h0000_1224);
    applyStimulus("or_r10", 4, 16'h000E);
    stepCycle();
    runStore("st_or", 16'h000F, 16'h0105, 32'hDEAD_BEFF);

    applyStimulus("beq_taken", 4, 16'h0010);
    checkOutput("beq_taken_pc", {16'h0, pc}, 32'h0040);
    stepCycle();
    applyStimulus("beq_not", 4, 16'h0040);
    checkOutput("beq_not_pc", {16'h0, pc}, 32'h0041);
    stepCycle();

    ldData = 32'h0000_0055;
    runLoad("ld_r0", 5, 16'h0041, 16'h0030);
    runStore("st_r0", 16'h0042, 16'h0106, 32'h0000_0000);

    applyStimulus("halt", 4, 16'h0043);
    stepCycle();
    checkOutput("halt_flag", {31'h0, halted}, 32'h1);
    checkOutput("halt_pc", {16'h0, pc}, 32'h0044);
    reqSeen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req || dmem_req || retire || !halted) reqSeen = 1'b1;
      stepCycle();
    end
    checkOutput("halt_quiet", {31'h0, reqSeen}, 32'h0);

    rst = 1'b1;
    stepCycle();
    checkOutput("rehalt_cleared", {31'h0, halted}, 32'h0);
    rst = 1'b0;
    applyStimulus("post_rst_add", 4, 16'h0000);
    stepCycle();
    imemWaits = 10;
    stepCycle();
    stepCycle();
    checkOutput("stall_req", {31'h0, imem_req}, 32'h1);
    checkOutput("stall_addr", {16'h0, imem_addr}, 32'h0001);
    rst = 1'b1;
    stepCycle();
    checkOutput("midrst_req", {31'h0, imem_req}, 32'h0);
    checkOutput("midrst_pc", {16'h0, pc}, 32'h0);
    rst = 1'b0;
    imemWaits = 0;
    applyStimulus("restart", 4, 16'h0000);
    checkOutput("restart_pc", {16'h0, pc}, 32'h1);

    checkOutput("no_dual_req", {31'h0, bothReq}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
